// File: rtl/trace_addr_feeder.sv
// Trace address feeder for configurable_cache.
// Turns a stream of signed address deltas into absolute byte addresses and
// queues them in a show-ahead FIFO that drives the cache's addr input.
module trace_addr_feeder #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            FIFO_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          delta_valid,
    output logic                          delta_ready,
    input  logic [ADDR_WIDTH-1:0]         delta,
    input  logic                          first,
    input  logic                          flush,
    output logic                          addr_valid,
    input  logic                          addr_ready,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   issued_count
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    // Storage and bookkeeping state
    logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0] acc_q, acc_d;
    logic [31:0]           issued_q, issued_d;

    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] new_addr;

    // Handshakes and show-ahead output; ready depends only on state and flush
    always_comb begin
        empty       = (count_q == '0);
        delta_ready = (count_q < DepthCnt) && !flush;
        addr_valid  = !empty;
        addr        = empty ? '0 : mem_q[rd_ptr_q];
        // Flush wins over a pop in the same cycle
        push        = delta_valid && delta_ready;
        pop         = addr_valid && addr_ready && !flush;
        // Modulo 2^ADDR_WIDTH accumulation, wraps both ways
        new_addr    = first ? delta : (acc_q + delta);
        fifo_count  = count_q;
        issued_count = issued_q;
    end

    // Next-state for pointers, occupancy, accumulator and issue counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        issued_d = issued_q;

        if (flush) begin
            // issued_q deliberately survives a flush
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            acc_d    = BASE_ADDR;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                acc_d    = new_addr;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                if (issued_q != 32'hFFFF_FFFF) begin
                    issued_d = issued_q + 32'd1;
                end
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= BASE_ADDR;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            issued_q <= issued_d;
        end
    end

    // Entry storage; contents need no reset since addr is gated by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_addr;
        end
    end

endmodule

// File: tb/tb_trace_addr_feeder.sv
// Self-checking bench for trace_addr_feeder: directed steps plus a random
// phase, all compared against a queue-based reference model.
module tb_trace_addr_feeder;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          delta_valid = 1'b0;
    logic          delta_ready;
    logic [AW-1:0] delta = '0;
    logic          first = 1'b0;
    logic          flush = 1'b0;
    logic          addr_valid;
    logic          addr_ready = 1'b0;
    logic [AW-1:0] addr;
    logic [3:0]    fifo_count;
    logic [31:0]   issued_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] macc;
    logic [31:0] missued;
    logic [31:0] popped[$];

    trace_addr_feeder #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .delta_valid  (delta_valid),
        .delta_ready  (delta_ready),
        .delta        (delta),
        .first        (first),
        .flush        (flush),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .addr         (addr),
        .fifo_count   (fifo_count),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [31:0] d,
                         input logic rdy, input logic fl);
        delta_valid = v;
        first       = f;
        delta       = d;
        addr_ready  = rdy;
        flush       = fl;
    endtask

    task automatic model_reset();
        mq.delete();
        macc    = BASE;
        missued = 32'd0;
    endtask

    task automatic check_outputs();
        check("addr_valid", {31'b0, addr_valid}, {31'b0, mq.size() != 0});
        check("addr", addr, (mq.size() != 0) ? mq[0] : 32'd0);
        check("fifo_count", {28'b0, fifo_count}, 32'(mq.size()));
        check("issued_count", issued_count, missued);
    endtask

    // One clock cycle: check ready, predict, clock, compare
    task automatic step();
        logic exp_rdy, do_push, do_pop;
        logic [31:0] na;
        #1;
        exp_rdy = (mq.size() < int'(DEPTH)) && !flush;
        check("delta_ready", {31'b0, delta_ready}, {31'b0, exp_rdy});
        do_push = delta_valid && exp_rdy;
        do_pop  = (mq.size() != 0) && addr_ready && !flush;
        if (addr_valid && addr_ready && !flush) popped.push_back(addr);
        na = first ? delta : macc + delta;
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            macc = BASE;
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                if (missued != 32'hFFFF_FFFF) missued++;
            end
            if (do_push) begin
                macc = na;
                mq.push_back(na);
            end
        end
        check_outputs();
    endtask

    initial begin
        model_reset();
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_delta_ready", {31'b0, delta_ready}, 32'd1);
        check_outputs();

        // Accumulate with a ready consumer
        drive(1, 1, 32'd100, 1, 0); step(); check("t2_a0", addr, 32'd100);
        drive(1, 0, 32'd4, 1, 0);   step(); check("t2_a1", addr, 32'd104);
        drive(1, 0, -32'sd8, 1, 0); step(); check("t2_a2", addr, 32'd96);
        drive(0, 0, 32'd0, 1, 0);   step(); check("t2_issued", issued_count, 32'd3);

        // Wrap in both directions
        drive(1, 1, 32'hFFFF_FFFC, 1, 0); step(); check("t3_a0", addr, 32'hFFFF_FFFC);
        drive(1, 0, 32'd8, 1, 0);         step(); check("t3_a1", addr, 32'h0000_0004);
        drive(1, 0, -32'sd12, 1, 0);      step(); check("t3_a2", addr, 32'hFFFF_FFF8);
        drive(0, 0, 32'd0, 1, 0);         step();

        // Backpressure: nine offers, eight accepted, head held at 0
        popped.delete();
        drive(1, 1, 32'd0, 0, 0); step();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'd1, 0, 0); step();
        end
        check("t4_full_count", {28'b0, fifo_count}, 32'd8);
        check("t4_full_head", addr, 32'd0);
        drive(1, 0, 32'd1, 1, 0); step();
        #1 check("t4_ready_after_pop", {31'b0, delta_ready}, 32'd1);
        step();
        drive(0, 0, 32'd0, 1, 0);
        for (int i = 0; i < 8; i++) step();
        check("t4_pop_total", 32'(popped.size()), 32'd9);
        for (int i = 0; i < popped.size() && i < 9; i++) begin
            check("t4_order", popped[i], 32'(i));
        end

        // Simultaneous push and pop at occupancy 3
        drive(1, 1, 32'd50, 0, 0); step();
        drive(1, 0, 32'd2, 0, 0);  step(); step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'd2, 1, 0); step();
            check("t5_count", {28'b0, fifo_count}, 32'd3);
        end
        drive(0, 0, 32'd0, 1, 0);
        repeat (4) step();

        // Flush with entries queued and a delta offered
        drive(1, 1, 32'd700, 0, 0); step();
        drive(1, 0, 32'd1, 0, 0);   step(); step();
        drive(1, 0, 32'd5, 1, 1);   step();
        check("t6_flush_count", {28'b0, fifo_count}, 32'd0);
        check("t6_flush_valid", {31'b0, addr_valid}, 32'd0);
        drive(1, 0, 32'd12, 0, 0);  step();
        check("t6_base_plus", addr, BASE + 32'd12);
        drive(1, 0, 32'd3, 0, 0);   step(); step();

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 32'd0, 0, 0);
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int d;
            d = int'($urandom_range(0, 64)) - 32;
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 3) == 0) ? $urandom : 32'(d),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trace_addr_feeder.md
Name: trace_addr_feeder

Overview:
- Upstream stimulus stage for configurable_cache.
- Accepts a stream of signed address deltas over a valid/ready handshake and accumulates them into absolute byte addresses.
- Buffers the addresses in a small show-ahead FIFO and presents them to the cache's addr input one per accepted cycle.
- Replaces the bench-side delta-to-address loop, so the trace can be streamed rather than preloaded into a 1.5M-entry array.

Parameters:
- ADDR_WIDTH, 32, width of deltas, accumulator and output address.
- FIFO_DEPTH, 8, address FIFO entries; power of two, minimum 2.
- BASE_ADDR, 0, accumulator value after reset or flush.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- delta_valid  input  1  delta and first are valid this cycle.
- delta_ready  output  1  feeder can accept a delta this cycle.
- delta  input  ADDR_WIDTH  signed two's-complement address delta.
- first  input  1  when 1, delta is loaded as an absolute address instead of being added.
- flush  input  1  synchronous clear of FIFO and accumulator.
- addr_valid  output  1  addr holds a valid queued address.
- addr_ready  input  1  consumer takes addr this cycle.
- addr  output  ADDR_WIDTH  absolute address at FIFO head.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- issued_count  output  32  total addresses popped, saturating.

Behaviour:
- Reset (async, rst=1), all of these take effect immediately:
  - acc=BASE_ADDR; read/write pointers=0; fifo_count=0.
  - addr_valid=0; addr=0; issued_count=0; delta_ready=1 once rst deasserts.
- Push occurs when delta_valid && delta_ready.
  - new_addr = first ? delta : acc + delta, computed modulo 2^ADDR_WIDTH (wrap in both directions, no saturation or error).
  - acc <= new_addr; new_addr is written at the write pointer; write pointer increments modulo FIFO_DEPTH.
- delta_ready = (fifo_count < FIFO_DEPTH) && !flush.
  - It is a registered-state function only, with no combinational path from addr_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- Output side is show-ahead:
  - addr_valid = (fifo_count != 0).
  - addr = entry at the read pointer when addr_valid, else 0.
- Pop occurs when addr_valid && addr_ready.
  - Read pointer increments modulo FIFO_DEPTH.
  - issued_count increments, holding at 32'hFFFFFFFF.
- Latency: an address pushed in cycle N is visible on addr/addr_valid in cycle N+1, whether or not the FIFO was empty.
- Simultaneous push and pop (not full): fifo_count is unchanged; both pointers advance.
- Order: addresses leave in strict push order; no reordering or dropping.
- Flush (sampled at clk edge) has priority over push and pop in that cycle.
  - Pointers, fifo_count and acc return to reset values; addr_valid=0 next cycle.
  - Any concurrent delta is discarded, and delta_ready is 0 during flush, so none is accepted.
  - issued_count is not cleared.
- Without first, the first delta after reset or flush is added to BASE_ADDR.
- addr is held stable while addr_valid && !addr_ready, as the consumer requires.
- Reset mid-stream discards queued addresses; no partial state survives.

Test Plan:
1. Reset: assert rst for 2 cycles, release -> addr_valid=0, addr=0, fifo_count=0, issued_count=0, delta_ready=1.
2. Accumulate, with addr_ready=1:
   - Stimulus: push first=1/delta=100, then delta=+4, then delta=-8.
   - Expected: addr shows 100, 104, 96 in consecutive cycles, each one cycle after its push; issued_count ends at 3.
3. Wrap-around:
   - Stimulus: first=1/delta=32'hFFFFFFFC, then delta=+8, then delta=-12.
   - Expected: addr shows 32'hFFFFFFFC, 32'h00000004, 32'hFFFFFFF8.
4. Backpressure, FIFO_DEPTH=8, addr_ready=0:
   - Stimulus: offer 9 deltas of +1 from first=1/delta=0.
   - Expected: 8 accepted; delta_ready=0 once fifo_count=8; addr held at 0.
   - Stimulus: raise addr_ready.
   - Expected: delta_ready=1 the cycle after the first pop; output sequence is 0..8 in order.
5. Simultaneous push and pop at count 3 for 5 cycles -> fifo_count stays 3; no loss or duplication.
6. Flush then reset:
   - Stimulus: flush with 3 entries queued and delta_valid=1.
   - Expected: next cycle fifo_count=0, addr_valid=0, delta not accepted.
   - Stimulus: delta=12 with first=0.
   - Expected: addr=BASE_ADDR+12.
   - Stimulus: async rst mid-stream.
   - Expected: outputs return to reset values without waiting for a clock edge.
